// File: rtl/cmac_accu_unit.sv
// Channel-group accumulator behind one MAC cell: sums len+1 partials per result,
// converts to OUT_W (saturate or truncate) and buffers results in a 2-entry FIFO.
module cmac_accu_unit #(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             cfg_reg_en,
    input  logic [CNT_W-1:0] cfg_accu_len,
    input  logic [CNT_W-1:0] cfg_grp_num,
    input  logic             cfg_sat_en,
    input  logic [IN_W-1:0]  mac_out_data,
    input  logic             mac_out_pvld,
    output logic [OUT_W-1:0] accu_out_data,
    output logic             accu_out_sat,
    output logic             accu_out_pvld,
    input  logic             accu_out_prdy,
    output logic             accu_busy,
    output logic             accu_done,
    output logic             accu_ovf_err
);

    localparam int unsigned EXT_W = ACC_W - IN_W;
    localparam int unsigned HI_W  = ACC_W - OUT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   grp_q, grp_d;
    logic               sat_en_q, sat_en_d;
    logic [CNT_W-1:0]   part_cnt_q, part_cnt_d;
    logic [CNT_W-1:0]   grp_cnt_q, grp_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   head_data_q, head_data_d;
    logic               head_sat_q, head_sat_d;
    logic               head_vld_q, head_vld_d;
    logic [OUT_W-1:0]   tail_data_q, tail_data_d;
    logic               tail_sat_q, tail_sat_d;
    logic               tail_vld_q, tail_vld_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [ACC_W-1:0]   sext_c;
    logic [ACC_W-1:0]   sum_c;
    logic [HI_W-1:0]    sum_hi_c;
    logic               out_of_range_c;
    logic [OUT_W-1:0]   res_data_c;
    logic               res_sat_c;
    logic               push_c;
    logic               pop_c;

    // Accumulate path and OUT_W conversion of the running sum
    always_comb begin
        sext_c         = {{EXT_W{mac_out_data[IN_W-1]}}, mac_out_data};
        sum_c          = (part_cnt_q == '0) ? sext_c : acc_q + sext_c;
        sum_hi_c       = sum_c[ACC_W-1:OUT_W-1];
        out_of_range_c = !((&sum_hi_c) || !(|sum_hi_c));
        res_data_c     = sum_c[OUT_W-1:0];
        res_sat_c      = 1'b0;
        if (sat_en_q && out_of_range_c) begin
            res_data_c = sum_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
            res_sat_c  = 1'b1;
        end
    end

    assign pop_c = head_vld_q & accu_out_prdy;

    // Next-state: FSM, counters, FIFO and status flags
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        grp_d       = grp_q;
        sat_en_d    = sat_en_q;
        part_cnt_d  = part_cnt_q;
        grp_cnt_d   = grp_cnt_q;
        acc_d       = acc_q;
        head_data_d = head_data_q;
        head_sat_d  = head_sat_q;
        head_vld_d  = head_vld_q;
        tail_data_d = tail_data_q;
        tail_sat_d  = tail_sat_q;
        tail_vld_d  = tail_vld_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        push_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_reg_en) begin
                    len_d      = cfg_accu_len;
                    grp_d      = cfg_grp_num;
                    sat_en_d   = cfg_sat_en;
                    part_cnt_d = '0;
                    grp_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (mac_out_pvld) begin
                    acc_d = sum_c;
                    if (part_cnt_q == len_q) begin
                        push_c     = 1'b1;
                        part_cnt_d = '0;
                        grp_cnt_d  = grp_cnt_q + 1'b1;
                        if (grp_cnt_q == grp_q) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        part_cnt_d = part_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Two-register FIFO: head feeds the output, tail holds the second entry
        case ({head_vld_q, tail_vld_q})
            2'b00: begin
                if (push_c) begin
                    head_data_d = res_data_c;
                    head_sat_d  = res_sat_c;
                    head_vld_d  = 1'b1;
                end
            end
            2'b10: begin
                if (pop_c && push_c) begin
                    head_data_d = res_data_c;
                    head_sat_d  = res_sat_c;
                end else if (pop_c) begin
                    head_vld_d = 1'b0;
                end else if (push_c) begin
                    tail_data_d = res_data_c;
                    tail_sat_d  = res_sat_c;
                    tail_vld_d  = 1'b1;
                end
            end
            2'b11: begin
                if (pop_c) begin
                    head_data_d = tail_data_q;
                    head_sat_d  = tail_sat_q;
                    if (push_c) begin
                        tail_data_d = res_data_c;
                        tail_sat_d  = res_sat_c;
                    end else begin
                        tail_vld_d = 1'b0;
                    end
                end else if (push_c) begin
                    ovf_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Done fires once the FIFO is seen empty going into the next cycle
        if (state_q == DRAIN && !head_vld_d) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            grp_q       <= '0;
            sat_en_q    <= 1'b0;
            part_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            acc_q       <= '0;
            head_data_q <= '0;
            head_sat_q  <= 1'b0;
            head_vld_q  <= 1'b0;
            tail_data_q <= '0;
            tail_sat_q  <= 1'b0;
            tail_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            grp_q       <= grp_d;
            sat_en_q    <= sat_en_d;
            part_cnt_q  <= part_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            acc_q       <= acc_d;
            head_data_q <= head_data_d;
            head_sat_q  <= head_sat_d;
            head_vld_q  <= head_vld_d;
            tail_data_q <= tail_data_d;
            tail_sat_q  <= tail_sat_d;
            tail_vld_q  <= tail_vld_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign accu_out_data = head_data_q;
    assign accu_out_sat  = head_sat_q;
    assign accu_out_pvld = head_vld_q;
    assign accu_busy     = busy_q;
    assign accu_done     = done_q;
    assign accu_ovf_err  = ovf_q;

endmodule

// File: doc/cmac_accu_unit.md
# cmac_accu_unit

Downstream accumulator for one MAC cell. Consumes the cell's registered 36-bit dot-product partial sums (`mac_out_data`/`mac_out_pvld`) and sums a programmed number of consecutive partials (channel groups) into one result. Results optionally saturate to 32 bits and are buffered in a 2-entry output FIFO with a valid/ready handshake. Upstream cannot be stalled, so FIFO overflow drops the result and raises a sticky error.

## Interface
- IN_W, 36, partial-sum width (signed)
- ACC_W, 48, accumulator width (signed)
- OUT_W, 32, result width (signed)
- CNT_W, 8, width of length/group counters
- nvdla_core_clk  in  1  single clock, all logic on rising edge
- nvdla_core_rst  in  1  reset; synchronous, active-high
- cfg_reg_en  in  1  start pulse; latches cfg_* in IDLE only
- cfg_accu_len  in  CNT_W  partials per result minus 1
- cfg_grp_num  in  CNT_W  results per layer minus 1
- cfg_sat_en  in  1  1 = saturate to OUT_W; 0 = truncate to low OUT_W bits
- mac_out_data  in  IN_W  signed partial sum
- mac_out_pvld  in  1  partial valid; no backpressure
- accu_out_data  out  OUT_W  result
- accu_out_sat  out  1  result was clipped (sat_en=1 only)
- accu_out_pvld  out  1  FIFO head valid
- accu_out_prdy  in  1  consumer ready
- accu_busy  out  1  state != IDLE
- accu_done  out  1  one-cycle pulse at layer end
- accu_ovf_err  out  1  sticky drop flag

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on `cfg_reg_en`. This latches len, grp, and sat_en, and clears part_cnt and grp_cnt. `cfg_reg_en` outside IDLE is ignored.
- In RUN, each `mac_out_pvld` updates the accumulator:
  - part_cnt==0: acc <= sext(data) (load, not add).
  - otherwise: acc <= acc + sext(data).
  - Sign-extend to ACC_W; the sum wraps modulo 2^ACC_W.
- When part_cnt==len with pvld, the group completes:
  - final = acc + sext(data), or sext(data) when len==0.
  - final is pushed into the FIFO and part_cnt returns to 0.
  - grp_cnt increments; if grp_cnt==grp, go RUN -> DRAIN.
  - Otherwise part_cnt increments per pvld.
- Output conversion:
  - sat_en=1: clip final to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 when clipped.
  - sat_en=0: low OUT_W bits; sat=0.
- DRAIN: wait for the FIFO to empty, then pulse `accu_done` for one cycle and return to IDLE.
- `mac_out_pvld` in IDLE or DRAIN is ignored; the accumulator and counters are unchanged.
- FIFO: 2 entries, ordered.
  - A pop occurs when pvld & prdy.
  - Push and pop in the same cycle are allowed at any occupancy, including full; occupancy is unchanged.
  - Push when full without a pop: the result is dropped, `accu_ovf_err` is set, and the counters still advance.
- `accu_ovf_err` clears only on reset.

## Timing
- Reset values:
  - State IDLE; all counters 0; acc 0; FIFO empty.
  - `accu_out_pvld`=0, `accu_out_data`=0, `accu_out_sat`=0, `accu_busy`=0, `accu_done`=0, `accu_ovf_err`=0.
- Reset mid-operation discards all in-flight and buffered results in the same cycle.
- `accu_busy` is 1 starting the cycle after `cfg_reg_en`.
- Latency is 1 cycle: the last partial in cycle T makes the result visible at the FIFO head in T+1 (FIFO empty) with `accu_out_pvld`=1.
- Back-to-back groups are supported with no bubble; a partial in the cycle after a group completes starts the next group via load.
- `accu_out_data` and `accu_out_sat` hold while pvld=1 and prdy=0.
- `accu_done` asserts the cycle after the FIFO becomes empty in DRAIN. If the last result pops the cycle it is written, `accu_done` is at T+2 of the last partial.

## Test plan
- len=3, grp=0, sat_en=0; partials 10, -3, 7, 100 on consecutive cycles with prdy=1 -> single result 114 one cycle after the 4th partial, sat=0. `accu_done` pulses once, then IDLE.
- len=0, grp=2; partials 5, 6, 7 back-to-back, prdy=1 -> results 5, 6, 7 on three consecutive cycles. No bubble.
- sat_en=1, len=1; partials 0x7FFFFFFF and 0x10 -> data 0x7FFFFFFF, sat=1. Partials -2^31 and -1 -> data 0x80000000, sat=1.
- sat_en=0 with the same inputs -> data 0x8000000F, sat=0.
- prdy=0, len=0, grp=3, four partials -> two results held, the 3rd and 4th dropped, `accu_ovf_err`=1. After prdy=1, exactly 2 results pop, then `accu_done`. Err stays 1.
- Reset asserted mid-group (part_cnt=2, one result buffered) -> next cycle IDLE, `accu_out_pvld`=0, `accu_ovf_err`=0. A new `cfg_reg_en` run produces correct sums.
- `cfg_reg_en` pulsed during RUN with a different len -> ignored; groups keep the original len. `mac_out_pvld` in IDLE produces no output.
